// File: rtl/ahb_arbiter.sv
// Four-master AHB bus arbiter: round-robin grant with burst, INCR and optional locked-transfer hold.
// Define AHB_ARB_LOCK_EN to honour HLOCK (LOCKED state, HMASTLOCK); otherwise HLOCK is ignored.
module ahb_arbiter (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [3:0] HBUSREQ,
    input  logic [3:0] HLOCK,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    output logic [3:0] HGRANT,
    output logic [1:0] HMASTER,
    output logic       HMASTLOCK
);

    localparam logic [1:0] S_ARB    = 2'd0;
    localparam logic [1:0] S_BURST  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    logic [1:0] r_state;
    logic [3:0] r_grant;
    logic [1:0] r_master;
    logic       r_mastlock;
    logic [3:0] r_cnt;
    logic [1:0] r_ptr;

    logic [1:0] w_gidx;
    logic       w_arb_hit;
    logic [1:0] w_arb_idx;
    logic       w_arb_lock;
    logic       w_lock_rel;
    logic       w_mlock_nxt;
    logic       w_burst_start;
    logic [3:0] w_burst_len;
    logic       w_incr_hold;
    logic       w_rearb;
    logic [1:0] w_state_nxt;
    logic [3:0] w_grant_nxt;
    logic [1:0] w_ptr_nxt;
    logic [3:0] w_cnt_nxt;

    function automatic logic [1:0] enc_grant(input logic [3:0] g);
        case (g)
            4'b0010: enc_grant = 2'd1;
            4'b0100: enc_grant = 2'd2;
            4'b1000: enc_grant = 2'd3;
            default: enc_grant = 2'd0;
        endcase
    endfunction

    assign w_gidx = enc_grant(r_grant);

    // Search begins one past the last granted master and wraps.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_arb_hit && HBUSREQ[r_ptr + 2'(k)]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = r_ptr + 2'(k);
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    assign w_arb_lock  = w_arb_hit & HLOCK[w_arb_idx];
    assign w_lock_rel  = ~HLOCK[w_gidx];
    assign w_mlock_nxt = HLOCK[w_gidx];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^HLOCK;
    assign w_arb_lock    = 1'b0;
    assign w_lock_rel    = 1'b1;
    assign w_mlock_nxt   = 1'b0;
`endif

    always_comb begin
        case (HBURST)
            3'd2, 3'd3: w_burst_len = 4'd3;
            3'd4, 3'd5: w_burst_len = 4'd7;
            3'd6, 3'd7: w_burst_len = 4'd15;
            default:    w_burst_len = 4'd0;
        endcase
    end

    assign w_burst_start = (HTRANS == TR_NONSEQ) && (HBURST >= 3'd2);
    assign w_incr_hold   = (HBURST == 3'd1) && (HTRANS != TR_IDLE) && HBUSREQ[w_gidx];

    // Counter holds remaining SEQ beats; the beat that takes it to zero re-arbitrates.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_rearb     = 1'b0;
        if (HREADY) begin
            case (r_state)
                S_ARB: begin
                    if (w_burst_start) begin
                        w_state_nxt = S_BURST;
                        w_cnt_nxt   = w_burst_len;
                    end else if (!w_incr_hold) begin
                        w_rearb = 1'b1;
                    end
                end
                S_BURST: begin
                    if (HTRANS == TR_IDLE || (HTRANS == TR_SEQ && r_cnt <= 4'd1))
                        w_rearb = 1'b1;
                    else if (HTRANS == TR_SEQ)
                        w_cnt_nxt = r_cnt - 4'd1;
                end
                S_LOCKED: w_rearb = w_lock_rel;
                default:  w_rearb = 1'b1;
            endcase
            if (w_rearb) begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = w_arb_lock ? S_LOCKED : S_ARB;
                if (w_arb_hit) begin
                    w_grant_nxt = 4'b0001 << w_arb_idx;
                    w_ptr_nxt   = w_arb_idx;
                end else begin
                    w_grant_nxt = 4'b0001;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= S_ARB;
            r_grant    <= 4'b0001;
            r_master   <= 2'd0;
            r_mastlock <= 1'b0;
            r_cnt      <= 4'd0;
            r_ptr      <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            if (HREADY) begin
                r_master   <= w_gidx;
                r_mastlock <= w_mlock_nxt;
            end
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: vector table through a scoreboard queue plus reset and lock sequences.
module tb_ahb_arbiter;

    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] NSQ = 2'd2;
    localparam logic [1:0] SEQ = 2'd3;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    ahb_arbiter dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
        .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic [3:0] grant;
        logic [1:0] master;
        logic       mlock;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] master;
        logic       mlock;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                                input logic [2:0] burst, input logic ready, input logic [3:0] grant,
                                input logic [1:0] master, input logic mlock);
        vec_t v;
        v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.ready = ready;
        v.grant = grant; v.master = master; v.mlock = mlock;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        HBUSREQ = v.req; HLOCK = v.lock; HTRANS = v.trans; HBURST = v.burst; HREADY = v.ready;
        e.grant = v.grant; e.master = v.master; e.mlock = v.mlock;
        sb.push_back(e);
        @(posedge HCLK);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 8'd0, 8'd1);
        end else begin
            got = sb.pop_front();
            check({tag, ".grant"}, {4'd0, HGRANT}, {4'd0, got.grant});
            check({tag, ".master"}, {6'd0, HMASTER}, {6'd0, got.master});
            check({tag, ".mlock"}, {7'd0, HMASTLOCK}, {7'd0, got.mlock});
            check({tag, ".onehot"}, {7'd0, $onehot(HGRANT)}, 8'd1);
        end
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        #2;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0; HBUSREQ = 4'd0; HLOCK = 4'd0; HTRANS = IDL; HBURST = 3'd0; HREADY = 1'b1;
        #12;
        check("reset.grant", {4'd0, HGRANT}, 8'h01);
        check("reset.master", {6'd0, HMASTER}, 8'h00);
        check("reset.mlock", {7'd0, HMASTLOCK}, 8'h00);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // rotation with all masters requesting SINGLE transfers
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b1000, 2'd2, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b0001, 2'd3, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0));
        // no requests: default master, pointer stays at 1
        tbl.push_back(mk(4'b0000, 4'b0, IDL, 3'd0, 1'b1, 4'b0001, 2'd1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0, IDL, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0, IDL, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0, IDL, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0, IDL, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1100, 4'b0, IDL, 3'd0, 1'b1, 4'b0100, 2'd0, 1'b0));
        // master 2 INCR4 with a two-cycle stall
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd3, 1'b1, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd3, 1'b1, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd3, 1'b0, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd3, 1'b0, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd3, 1'b1, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd3, 1'b1, 4'b1000, 2'd2, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, IDL, 3'd0, 1'b1, 4'b0001, 2'd3, 1'b0));
        // master 1 WRAP8 terminated early with IDLE after beat 3
        tbl.push_back(mk(4'b0010, 4'b0, IDL, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd4, 1'b1, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd4, 1'b1, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd4, 1'b1, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, IDL, 3'd4, 1'b1, 4'b0100, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, IDL, 3'd0, 1'b1, 4'b1000, 2'd2, 1'b0));
        // INCR held by master 3 until its request drops
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd1, 1'b1, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd1, 1'b1, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(mk(4'b0111, 4'b0, SEQ, 3'd1, 1'b1, 4'b0001, 2'd3, 1'b0));
        // master 1 INCR8, reset lands at beat 3
        tbl.push_back(mk(4'b1111, 4'b0, IDL, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, NSQ, 3'd5, 1'b1, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd5, 1'b1, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0, SEQ, 3'd5, 1'b1, 4'b0010, 2'd1, 1'b0));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        HRESETn = 1'b0;
        #2;
        check("async_rst.grant", {4'd0, HGRANT}, 8'h01);
        check("async_rst.master", {6'd0, HMASTER}, 8'h00);
        check("async_rst.mlock", {7'd0, HMASTLOCK}, 8'h00);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        // SEQ after release must re-arbitrate: no residual burst hold
        step(mk(4'b1111, 4'b0, SEQ, 3'd5, 1'b1, 4'b0010, 2'd0, 1'b0), "post_rst0");
        step(mk(4'b1111, 4'b0, SEQ, 3'd5, 1'b1, 4'b0100, 2'd1, 1'b0), "post_rst1");

        do_reset();
`ifdef AHB_ARB_LOCK_EN
        step(mk(4'b1000, 4'b1000, NSQ, 3'd0, 1'b1, 4'b1000, 2'd0, 1'b0), "lock0");
        step(mk(4'b1111, 4'b1000, NSQ, 3'd0, 1'b1, 4'b1000, 2'd3, 1'b1), "lock1");
        step(mk(4'b1111, 4'b1000, NSQ, 3'd0, 1'b1, 4'b1000, 2'd3, 1'b1), "lock2");
        step(mk(4'b1111, 4'b0000, NSQ, 3'd0, 1'b1, 4'b0001, 2'd3, 1'b0), "lock3");
        step(mk(4'b1111, 4'b0000, NSQ, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0), "lock4");
`else
        step(mk(4'b1000, 4'b1000, NSQ, 3'd0, 1'b1, 4'b1000, 2'd0, 1'b0), "lock0");
        step(mk(4'b1111, 4'b1000, NSQ, 3'd0, 1'b1, 4'b0001, 2'd3, 1'b0), "lock1");
        step(mk(4'b1111, 4'b1000, NSQ, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0), "lock2");
        step(mk(4'b1111, 4'b0000, NSQ, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0), "lock3");
        step(mk(4'b1111, 4'b0000, NSQ, 3'd0, 1'b1, 4'b1000, 2'd2, 1'b0), "lock4");
`endif

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 The block SHALL have NUM_M = 4 requesting masters, fixed, not a parameter.
REQ-002 Port HCLK, input, 1 bit: sole clock; all state SHALL update on its rising edge.
REQ-003 Port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port HBUSREQ, input, 4 bits: bus request, one bit per master.
REQ-005 Port HLOCK, input, 4 bits: locked-transfer request, one bit per master.
REQ-006 Port HTRANS, input, 2 bits: transfer type of the currently muxed master; 0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
REQ-007 Port HBURST, input, 3 bits: burst type of the currently muxed master.
REQ-008 Port HREADY, input, 1 bit: slave ready; low extends the current data phase.
REQ-009 Port HGRANT, output, 4 bits: registered one-hot grant.
REQ-010 Port HMASTER, output, 2 bits: index of the master owning the address phase; drives the master-side mux.
REQ-011 Port HMASTLOCK, output, 1 bit: current address phase is locked.

Function
REQ-012 The block SHALL implement FSM states ARB, BURST and LOCKED.
REQ-013 ARB: re-arbitration SHALL occur on every cycle with HREADY=1; the new HGRANT SHALL be registered at that edge.
REQ-014 Round-robin: the search SHALL start at (last granted index + 1) mod 4, and the first master with HBUSREQ=1 SHALL win.
REQ-015 No requests: HGRANT SHALL equal 4'b0001 (master 0 is the default master), and the round-robin pointer SHALL stay unchanged.
REQ-016 HTRANS=NONSEQ with HREADY=1 and HBURST in {2..7} SHALL load a beat counter with remaining beats (4/8/16 minus 1) and enter BURST.
REQ-017 BURST: each HREADY=1 with HTRANS=SEQ SHALL decrement the counter; BUSY or HREADY=0 SHALL hold it; HGRANT SHALL be frozen.
REQ-018 BURST exit: when the counter reaches 0 on an accepted SEQ beat, the block SHALL re-arbitrate on that edge and return to ARB.
REQ-019 HTRANS=IDLE during BURST (early termination) SHALL return the block to ARB and re-arbitrate on that edge.
REQ-020 HBURST=1 (INCR): HGRANT SHALL be held while the owner's HBUSREQ=1 and HTRANS is not IDLE; otherwise normal arbitration.
REQ-021 HBURST=0 (SINGLE) SHALL keep the block in ARB.
REQ-022 HMASTER SHALL load the encoded HGRANT on every rising edge with HREADY=1 and hold while HREADY=0, giving one cycle of lag behind HGRANT.
REQ-023 Simultaneous burst end and new requests: the winner SHALL be taken from the round-robin search on the same edge; no idle cycle SHALL be inserted.
REQ-024 HGRANT SHALL always be exactly one-hot.

Reset
REQ-025 HRESETn=0 SHALL asynchronously force state ARB, HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0, beat counter 0 and round-robin pointer 0.
REQ-026 Reset asserted mid-burst or mid-lock SHALL abandon the sequence; after release, arbitration SHALL start fresh.

Configuration
REQ-027 Macro AHB_ARB_LOCK_EN defined: when the granted master has HLOCK=1 at arbitration, the block SHALL enter LOCKED.
REQ-028 In LOCKED, HGRANT SHALL hold until that master drops HLOCK and completes one HREADY=1 cycle.
REQ-029 With AHB_ARB_LOCK_EN defined, HMASTLOCK SHALL equal the registered HLOCK of the HMASTER owner, updated with HMASTER.
REQ-030 Macro AHB_ARB_LOCK_EN undefined: HLOCK SHALL be ignored, LOCKED SHALL be unreachable and HMASTLOCK SHALL be tied to 0.

Verification
REQ-031 Reset: HRESETn low mid-INCR8 at beat 3 -> HGRANT=0001, HMASTER=0 immediately; no residual BURST state after release.
REQ-032 Round-robin: HBUSREQ=4'b1111 constant, SINGLE transfers, HREADY=1 -> grant order 1,2,3,0,1 on consecutive cycles; HMASTER trails by 1 cycle.
REQ-033 Burst hold: master 2 INCR4 with HBUSREQ=4'b1111, and HREADY=0 for 2 cycles on beat 2 -> grant stays 0100 for all 4 beats plus stalls, then moves to 1000.
REQ-034 Early termination: master 1 WRAP8 sends HTRANS=IDLE after beat 3 -> state ARB and re-arbitration on that edge.
REQ-035 Default master: HBUSREQ=0 for 5 cycles -> HGRANT=0001 throughout; pointer unchanged, so the next request from masters 2 and 3 grants master 2 when the last grant was 1.
REQ-036 Lock (macro defined): master 3 HLOCK=1 for 3 SINGLE transfers -> HGRANT=1000 and HMASTLOCK=1 until one cycle after HLOCK falls; with the macro undefined, grants rotate and HMASTLOCK=0.
